// File: rtl/cpu_bus_sequencer.sv
// T-cycle sequencer between microcode control and the external bus.
// Runs T0..T3 per M-cycle and stretches T2 for wait states with a timeout.
module cpu_bus_sequencer #(
    parameter int         MAX_WAIT = 15,
    parameter logic [7:0] OPEN_BUS = 8'hFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        mem_enable,
    input  logic        mem_write,
    input  logic [15:0] addr_in,
    input  logic [7:0]  wdata_in,
    output logic [1:0]  t_cycle,
    output logic [7:0]  mem_data_in,
    output logic        m_cycle_end,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    output logic        ext_rd,
    output logic        ext_wr,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_ready,
    output logic        bus_error
);

    localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstate_t;

    tstate_t state, state_d;

    logic          active, active_d;
    logic          wr, wr_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_q_d;
    logic [7:0]    data_q, data_d;
    logic          err_q, err_d;
    logic [WW-1:0] wait_cnt, wait_cnt_d;

    logic waiting;
    logic timeout;
    logic adv;

    // A target that is not ready holds T2 until the wait budget runs out.
    assign waiting = (state == T2) && active && !ext_ready;
    assign timeout = waiting && (wait_cnt == WW'(MAX_WAIT));
    assign adv     = clk_en && (!waiting || timeout);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= T0;
            active   <= 1'b0;
            wr       <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            data_q   <= OPEN_BUS;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state    <= state_d;
            active   <= active_d;
            wr       <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_q_d;
            data_q   <= data_d;
            err_q    <= err_d;
            wait_cnt <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        active_d   = active;
        wr_d       = wr;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wr_q_d     = wr_q;
        data_d     = data_q;
        err_d      = err_q;
        wait_cnt_d = wait_cnt;

        if (adv) begin
            state_d = tstate_t'(state + 2'd1);
        end

        if (clk_en) begin
            unique case (state)
                T0: begin
                    active_d = mem_enable;
                    wr_d     = mem_write;
                    rd_d     = mem_enable && !mem_write;
                    wr_q_d   = 1'b0;
                    if (mem_enable) begin
                        addr_d  = addr_in;
                        wdata_d = wdata_in;
                    end
                end
                T1: begin
                    wr_q_d = active && wr;
                end
                T2: begin
                    if (!waiting) begin
                        if (active && !wr) begin
                            data_d = ext_rdata;
                        end
                        rd_d       = 1'b0;
                        wr_q_d     = 1'b0;
                        wait_cnt_d = '0;
                    end else if (timeout) begin
                        // Timed-out reads float the bus; writes are lost.
                        if (!wr) begin
                            data_d = OPEN_BUS;
                        end
                        err_d      = 1'b1;
                        rd_d       = 1'b0;
                        wr_q_d     = 1'b0;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt + 1'b1;
                    end
                end
                T3: begin
                    rd_d   = 1'b0;
                    wr_q_d = 1'b0;
                end
                default: begin
                    state_d = T0;
                end
            endcase
        end
    end

    assign t_cycle     = state;
    assign m_cycle_end = clk_en && (state == T3);
    assign mem_data_in = data_q;
    assign ext_addr    = addr_q;
    assign ext_wdata   = wdata_q;
    assign ext_rd      = rd_q;
    assign ext_wr      = wr_q;
    assign bus_error   = err_q;

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Randomised and directed bench for cpu_bus_sequencer.
// A per-clock behavioural model predicts every output each cycle.
module tb_cpu_bus_sequencer;

    localparam int MAXW = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_en;
    logic        mem_enable;
    logic        mem_write;
    logic [15:0] addr_in;
    logic [7:0]  wdata_in;
    logic [1:0]  t_cycle;
    logic [7:0]  mem_data_in;
    logic        m_cycle_end;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_rd;
    logic        ext_wr;
    logic [7:0]  ext_rdata;
    logic        ext_ready;
    logic        bus_error;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    cpu_bus_sequencer #(.MAX_WAIT(MAXW), .OPEN_BUS(8'hFF)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .clk_en(clk_en),
        .mem_enable(mem_enable),
        .mem_write(mem_write),
        .addr_in(addr_in),
        .wdata_in(wdata_in),
        .t_cycle(t_cycle),
        .mem_data_in(mem_data_in),
        .m_cycle_end(m_cycle_end),
        .ext_addr(ext_addr),
        .ext_wdata(ext_wdata),
        .ext_rd(ext_rd),
        .ext_wr(ext_wr),
        .ext_rdata(ext_rdata),
        .ext_ready(ext_ready),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    // Model state: phase number, request of this M-cycle, stall count.
    int          m_t = 0;
    int          m_wait = 0;
    bit          m_act = 0;
    bit          m_wr = 0;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_wd = '0;
    logic [7:0]  m_data = 8'hFF;
    bit          m_err = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_t <= 0; m_wait <= 0; m_act <= 0; m_wr <= 0;
            m_addr <= '0; m_wd <= '0; m_data <= 8'hFF; m_err <= 0;
        end else if (clk_en) begin
            if (m_t == 0) begin
                m_act <= mem_enable;
                m_wr  <= mem_write;
                if (mem_enable) begin
                    m_addr <= addr_in;
                    m_wd   <= wdata_in;
                end
                m_t <= 1;
            end else if (m_t == 1) begin
                m_t <= 2;
            end else if (m_t == 2) begin
                if (!m_act || ext_ready) begin
                    if (m_act && !m_wr) m_data <= ext_rdata;
                    m_t <= 3; m_wait <= 0;
                end else if (m_wait == MAXW) begin
                    if (!m_wr) m_data <= 8'hFF;
                    m_err <= 1; m_t <= 3; m_wait <= 0;
                end else begin
                    m_wait <= m_wait + 1;
                end
            end else begin
                m_t <= 0;
            end
        end
    end

    task automatic cmp(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("t_cycle", 16'(t_cycle), 16'(m_t));
            cmp("mem_data_in", 16'(mem_data_in), 16'(m_data));
            cmp("ext_rd", 16'(ext_rd),
                16'(m_act && !m_wr && (m_t == 1 || m_t == 2)));
            cmp("ext_wr", 16'(ext_wr), 16'(m_act && m_wr && m_t == 2));
            cmp("ext_addr", ext_addr, m_addr);
            cmp("ext_wdata", 16'(ext_wdata), 16'(m_wd));
            cmp("bus_error", 16'(bus_error), 16'(m_err));
            cmp("m_cycle_end", 16'(m_cycle_end),
                16'(clk_en && m_t == 3));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input bit me, input bit mw, input logic [15:0] a,
                       input logic [7:0] d);
        mem_enable = me; mem_write = mw; addr_in = a; wdata_in = d;
    endtask

    task automatic sync_t0();
        clk_en = 1'b1; ext_ready = 1'b1;
        req(1'b0, 1'b0, 16'h0000, 8'h00);
        for (int i = 0; i < 8 && t_cycle != 2'd0; i++) tick();
        cmp("sync_t0", 16'(t_cycle), 16'd0);
    endtask

    int pulses;
    int hold;

    initial begin
        reset_n = 1'b0; clk_en = 1'b0;
        req(1'b0, 1'b0, 16'h0000, 8'h00);
        ext_rdata = 8'h00; ext_ready = 1'b1;
        tick();
        chk_on = 1'b1;
        cmp("rst_t", 16'(t_cycle), 16'd0);
        cmp("rst_data", 16'(mem_data_in), 16'h00FF);
        cmp("rst_err", 16'(bus_error), 16'd0);
        reset_n = 1'b1;

        // Read, zero wait.
        sync_t0();
        req(1'b1, 1'b0, 16'hC000, 8'h00);
        ext_rdata = 8'h3E;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_cycle_end) pulses++;
            tick();
            if (i == 0) cmp("rd0_addr", ext_addr, 16'hC000);
            req(1'b0, 1'b0, 16'h0000, 8'h00);
        end
        cmp("rd0_pulses", 16'(pulses), 16'd1);
        cmp("rd0_t", 16'(t_cycle), 16'd0);
        cmp("rd0_data", 16'(mem_data_in), 16'h003E);
        cmp("rd0_model", 16'(m_data), 16'h003E);

        // Write.
        req(1'b1, 1'b1, 16'hFF80, 8'h5A);
        tick();
        cmp("wr_wdata", 16'(ext_wdata), 16'h005A);
        tick();
        cmp("wr_strobe", 16'(ext_wr), 16'd1);
        for (int i = 0; i < 2; i++) tick();
        cmp("wr_data_kept", 16'(mem_data_in), 16'h003E);

        // Three wait clocks then ready.
        sync_t0();
        req(1'b1, 1'b0, 16'h1234, 8'h00);
        tick(); tick();
        ext_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("ws_hold", 16'(t_cycle), 16'd2);
        end
        ext_ready = 1'b1; ext_rdata = 8'h77;
        tick(); tick();
        cmp("ws_len", 16'(t_cycle), 16'd0);
        cmp("ws_data", 16'(mem_data_in), 16'h0077);
        cmp("ws_err", 16'(bus_error), 16'd0);

        // Timeout.
        req(1'b1, 1'b0, 16'h4000, 8'h00);
        tick(); tick();
        ext_ready = 1'b0;
        for (int i = 0; i < MAXW; i++) tick();
        cmp("to_still_t2", 16'(t_cycle), 16'd2);
        tick();
        cmp("to_adv", 16'(t_cycle), 16'd3);
        cmp("to_data", 16'(mem_data_in), 16'h00FF);
        cmp("to_err", 16'(bus_error), 16'd1);
        sync_t0();
        req(1'b1, 1'b0, 16'h4001, 8'h00);
        ext_rdata = 8'h12;
        for (int i = 0; i < 4; i++) tick();
        cmp("to_sticky", 16'(bus_error), 16'd1);
        cmp("to_clean_data", 16'(mem_data_in), 16'h0012);

        // clk_en gating during a read.
        req(1'b1, 1'b0, 16'h2222, 8'h00);
        ext_rdata = 8'hAB;
        for (int i = 0; i < 7; i++) begin
            clk_en = (i % 2 == 0);
            tick();
        end
        clk_en = 1'b1;
        cmp("gate_t", 16'(t_cycle), 16'd0);
        cmp("gate_data", 16'(mem_data_in), 16'h00AB);

        // Reset during a T2 wait.
        req(1'b1, 1'b0, 16'h3333, 8'h00);
        tick(); tick();
        ext_ready = 1'b0;
        tick(); tick();
        reset_n = 1'b0;
        tick();
        cmp("rst2_t", 16'(t_cycle), 16'd0);
        cmp("rst2_rd", 16'(ext_rd), 16'd0);
        cmp("rst2_data", 16'(mem_data_in), 16'h00FF);
        cmp("rst2_err", 16'(bus_error), 16'd0);
        reset_n = 1'b1; ext_ready = 1'b1; ext_rdata = 8'h5C;
        req(1'b1, 1'b0, 16'h3334, 8'h00);
        for (int i = 0; i < 4; i++) tick();
        cmp("rst2_after", 16'(mem_data_in), 16'h005C);

        // Random traffic.
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            reset_n    = ($urandom % 500) != 0;
            clk_en     = ($urandom % 4) != 0;
            mem_enable = ($urandom % 4) != 0;
            mem_write  = $urandom % 2;
            addr_in    = 16'($urandom);
            wdata_in   = 8'($urandom);
            ext_rdata  = 8'($urandom);
            if (hold > 0) begin
                ext_ready = 1'b0;
                hold--;
            end else begin
                ext_ready = ($urandom % 3) != 0;
                if ($urandom % 80 == 0) hold = 25;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_bus_sequencer.md
Name: cpu_bus_sequencer

Overview:
- Sits directly downstream of the CPU microcode control stage. It owns the T-cycle counter that control consumes.
- Turns control's per-M-cycle memory request (`mem_enable`, `mem_write`, address, write data) into a timed external bus transaction.
- Returns the captured read byte to control as `mem_data_in`, in time for the end-of-T3 dispatch.
- Supports wait states from slow or arbitrated targets, with a timeout.

Parameters:
- MAX_WAIT, 15: maximum number of T2 wait clocks before the transaction is forced to complete.
- OPEN_BUS, 8'hFF: value returned on timeout and held in `mem_data_in` after reset.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset, synchronous, active-low.
- clk_en  input  1  T-cycle advance enable. When low, all state is frozen.
- mem_enable  input  1  from control: this M-cycle accesses memory.
- mem_write  input  1  from control: the access is a write (qualified by `mem_enable`).
- addr_in  input  16  resolved memory address for this M-cycle.
- wdata_in  input  8  write data for this M-cycle.
- t_cycle  output  2  current T-cycle, 0..3, to control.
- mem_data_in  output  8  last captured read byte, to control.
- m_cycle_end  output  1  high during a T3 clock that advances.
- ext_addr  output  16  external bus address.
- ext_wdata  output  8  external bus write data.
- ext_rd  output  1  external read strobe.
- ext_wr  output  1  external write strobe.
- ext_rdata  input  8  external read data.
- ext_ready  input  1  target ready; sampled only in T2 of an active access.
- bus_error  output  1  sticky flag: a timeout has occurred.

Behaviour:
- Reset (`reset_n` low at a clk edge) forces these values on the same edge, regardless of `clk_en` or any in-flight transaction:
  - `t_cycle` = 0, `mem_data_in` = OPEN_BUS, `ext_addr` = 0, `ext_wdata` = 0.
  - `ext_rd` = 0, `ext_wr` = 0, `bus_error` = 0, wait counter = 0, `active` = 0.
- Advance: an edge "advances" when `clk_en`=1 and the block is not stalled. `t_cycle` goes 0→1→2→3→0.
- `m_cycle_end` = `clk_en` & (`t_cycle`==3). It is combinational, because T3 never stalls.
- Request latch: on the advancing edge leaving T0, capture `mem_enable`, `mem_write`, `addr_in`, `wdata_in` into `active`, `wr`, `ext_addr`, `ext_wdata`. Request inputs are ignored at every other time.
  - When `mem_enable`=0, `ext_addr` and `ext_wdata` hold their previous values.
- Strobes are registered and valid through T1..T3:
  - Read: `ext_rd`=1 during T1 and T2, including wait clocks.
  - Write: `ext_wr`=1 during T2 only, including wait clocks. `ext_wdata` is stable T1..T3.
  - Both strobes drop on the edge entering T3. They are never both high.
- Wait state: in T2 with `active`=1 and `ext_ready`=0, the block stalls. `t_cycle` holds at 2 and the wait counter increments on each `clk_en` edge.
- Read capture: on the edge leaving T2 with `active` & !`wr` & `ext_ready`, `mem_data_in` <= `ext_rdata`.
  - `mem_data_in` is stable from T3 until the next capture.
  - Writes and idle cycles leave it unchanged.
- Timeout: in T2, if the wait counter == MAX_WAIT and `ext_ready`=0, the block advances anyway.
  - A read returns OPEN_BUS into `mem_data_in`; a write is dropped.
  - `bus_error` <= 1 and stays set until reset.
- The wait counter clears on leaving T2. Its width is clog2(MAX_WAIT+1).
- Idle M-cycle (`active`=0): no stall, no strobes, `ext_ready` is ignored.
- Control sees a stalled cycle as a lengthened T2. Because the microcode state updates only at `t_cycle`==3, no other handshake is needed.

Test Plan:
- Read, zero wait:
  - Stimulus: `addr_in`=16'hC000, `mem_enable`=1, `ext_ready`=1, `ext_rdata`=8'h3E.
  - Response: `ext_rd` high for T1–T2 only, `ext_addr`=C000 from T1, `mem_data_in`=3E at T3, `m_cycle_end` one pulse, 4 clocks total.
- Write:
  - Stimulus: `mem_write`=1, `addr_in`=FF80, `wdata_in`=5A.
  - Response: `ext_wr` high exactly in T2, `ext_wdata`=5A stable T1–T3, `mem_data_in` unchanged.
- Wait states:
  - Stimulus: `ext_ready` low for 3 clocks in T2, then high with `ext_rdata`=77.
  - Response: `t_cycle` holds at 2 for 4 clocks, M-cycle = 7 clocks, `mem_data_in`=77, `bus_error`=0.
- Timeout:
  - Stimulus: `ext_ready` held low.
  - Response: advance after MAX_WAIT+1 T2 clocks (16), `mem_data_in`=FF, `bus_error`=1 and still 1 after the next clean cycle.
- `clk_en` gating:
  - Stimulus: toggle `clk_en` 1/0 during a read.
  - Response: `t_cycle`, strobes and the wait counter change only on `clk_en`=1 edges, with results identical to the ungated read.
- Reset mid-transaction:
  - Stimulus: `reset_n` low during a T2 wait.
  - Response: the next edge gives `t_cycle`=0, `ext_rd`=0, `mem_data_in`=FF, `bus_error`=0; an access issued after release completes normally.
